// File: rtl/psum_drain_if.sv
//------------------------------------------------------------------------------
// Module  : psum_drain_if
// Brief   : Capture and drain stream bundle between MAC row, psum_drain and SRAM writer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface psum_drain_if #(
    parameter int PSUM_BW = 20,
    parameter int COL     = 4
);
    localparam int CW = $clog2(COL);

    logic                      in_valid;
    logic signed [PSUM_BW-1:0] in_psum [COL-1:0];
    logic                      relu_en;
    logic                      out_ready;
    logic                      out_valid;
    logic signed [PSUM_BW-1:0] out_psum;
    logic [CW-1:0]             out_col;
    logic                      out_last;

    // The environment (row + consumer) drives master; psum_drain sits on slave.
    modport master (
        output in_valid, in_psum, relu_en, out_ready,
        input  out_valid, out_psum, out_col, out_last
    );

    modport slave (
        input  in_valid, in_psum, relu_en, out_ready,
        output out_valid, out_psum, out_col, out_last
    );
endinterface

`default_nettype wire

// File: rtl/psum_drain.sv
//------------------------------------------------------------------------------
// Module  : psum_drain
// Brief   : Vector FIFO behind the MAC row; drains one psum word per cycle with optional ReLU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psum_drain #(
    parameter int PSUM_BW = 20,
    parameter int COL     = 4,
    parameter int DEPTH   = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    psum_drain_if.slave               bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow
);
    localparam int CW = $clog2(COL);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] c_LAST_COL  = CW'(COL-1);

    logic [PSUM_BW-1:0] r_mem [DEPTH-1:0][COL-1:0];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_col_idx;
    logic [AW:0]        r_count;
    logic               r_overflow;

    logic               w_fire;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic [PSUM_BW-1:0] w_raw;

    assign w_fire = bus.out_valid && bus.out_ready;
    assign w_pop  = w_fire && (r_col_idx == c_LAST_COL);
    // A full FIFO still accepts a capture when the head vector leaves on the same edge.
    assign w_wr   = bus.in_valid && ((r_count != c_DEPTH_CNT) || w_pop);
    assign w_drop = bus.in_valid && !w_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_col_idx  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire) begin
                r_col_idx <= r_col_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int c = 0; c < COL; c++) begin
                r_mem[r_wr_ptr][c] <= bus.in_psum[c];
            end
        end
    end

    assign w_raw         = r_mem[r_rd_ptr][r_col_idx];
    assign bus.out_valid = (r_count != '0);
    assign bus.out_psum  = (bus.relu_en && w_raw[PSUM_BW-1]) ? '0 : w_raw;
    assign bus.out_col   = r_col_idx;
    assign bus.out_last  = bus.out_valid && (r_col_idx == c_LAST_COL);

    assign count    = r_count;
    assign full     = (r_count == c_DEPTH_CNT);
    assign overflow = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_psum_drain.sv
//------------------------------------------------------------------------------
// Module  : tb_psum_drain
// Brief   : Scoreboard bench for psum_drain: directed vectors, decoupled output monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_psum_drain;
    localparam int PSUM_BW = 20;
    localparam int COL     = 4;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic       full;
    logic       overflow;

    psum_drain_if #(.PSUM_BW(PSUM_BW), .COL(COL)) bus ();

    psum_drain #(.PSUM_BW(PSUM_BW), .COL(COL), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int raw;
        int col;
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   prev_stall = 1'b0;
    int   prev_psum;
    int   prev_col;

    function automatic void chk(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on every accepted word, checks hold during stalls.
    always @(negedge clk) begin : mon
        exp_t e;
        int   ex;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_word: got %0d col %0d with empty scoreboard at %0t",
                         $signed(bus.out_psum), bus.out_col, $time);
            end else begin
                e  = sb.pop_front();
                ex = (bus.relu_en && e.raw < 0) ? 0 : e.raw;
                chk("out_psum", $signed(bus.out_psum), ex);
                chk("out_col", {30'd0, bus.out_col}, e.col);
                chk("out_last", {31'd0, bus.out_last}, (e.col == COL-1) ? 1 : 0);
            end
            prev_stall = 1'b0;
        end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            if (prev_stall) begin
                chk("stall_psum", $signed(bus.out_psum), prev_psum);
                chk("stall_col", {30'd0, bus.out_col}, prev_col);
            end
            prev_stall = 1'b1;
            prev_psum  = $signed(bus.out_psum);
            prev_col   = int'(bus.out_col);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int v [4], input bit accept);
        for (int c = 0; c < COL; c++) begin
            bus.in_psum[c] = v[c][PSUM_BW-1:0];
            if (accept) sb.push_back('{raw: v[c], col: c});
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic cap_pattern(input int base, input bit accept);
        int v [4];
        v = '{base + 1, -(base + 2), base + 3, -(base + 4)};
        capture(v, accept);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((bus.out_valid !== 1'b0 || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drained_valid"}, {31'd0, bus.out_valid}, 0);
        chk({name, "_drained_sb"}, sb.size(), 0);
    endtask

    // Asserts reset between edges and checks the immediate clear.
    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_full", {31'd0, full}, 0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < COL; c++) bus.in_psum[c] = '0;
        tick();
        tick();

        chk("init_out_valid", {31'd0, bus.out_valid}, 0);
        chk("init_out_col", {30'd0, bus.out_col}, 0);
        chk("init_out_last", {31'd0, bus.out_last}, 0);
        chk("init_count", {28'd0, count}, 0);
        chk("init_full", {31'd0, full}, 0);
        chk("init_overflow", {31'd0, overflow}, 0);
        reset = 1'b1;
        tick();

        // Single vector, no ReLU
        bus.out_ready = 1'b1;
        capture('{-5, 7, 0, 100}, 1'b1);
        chk("lat_out_valid", {31'd0, bus.out_valid}, 1);
        chk("lat_out_col", {30'd0, bus.out_col}, 0);
        chk("lat_count", {28'd0, count}, 1);
        wait_drain("single");
        chk("single_count_end", {28'd0, count}, 0);

        // ReLU whole vector, then per-word toggle
        bus.relu_en = 1'b1;
        capture('{-5, 7, 0, 100}, 1'b1);
        wait_drain("relu");
        capture('{-1, -2, 3, -4}, 1'b1);
        for (int i = 0; i < COL; i++) begin
            bus.relu_en = (i % 2 == 1);
            tick();
        end
        bus.relu_en = 1'b0;
        wait_drain("relu_toggle");

        // Back-pressure on column 2
        capture('{11, -22, 33, -44}, 1'b1);
        tick();
        tick();
        chk("bp_at_col2", {30'd0, bus.out_col}, 2);
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("bp_hold_col", {30'd0, bus.out_col}, 2);
        chk("bp_hold_valid", {31'd0, bus.out_valid}, 1);
        bus.out_ready = 1'b1;
        wait_drain("backpressure");

        // Fill to full, ninth capture dropped
        bus.out_ready = 1'b0;
        for (int v = 0; v < DEPTH + 1; v++) begin
            cap_pattern(v * 10, v < DEPTH);
            if (v == DEPTH - 1) begin
                chk("fill_full", {31'd0, full}, 1);
                chk("fill_count", {28'd0, count}, DEPTH);
                chk("fill_no_ovf", {31'd0, overflow}, 0);
            end
        end
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("ovf_count", {28'd0, count}, DEPTH);
        bus.out_ready = 1'b1;
        wait_drain("fill");
        chk("fill_count_end", {28'd0, count}, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // Full with simultaneous write and pop
        pulse_reset();
        bus.out_ready = 1'b0;
        for (int v = 0; v < DEPTH; v++) cap_pattern(200 + v * 10, 1'b1);
        chk("sim_full_before", {31'd0, full}, 1);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("sim_at_last", {31'd0, bus.out_last}, 1);
        cap_pattern(990, 1'b1);
        chk("sim_count", {28'd0, count}, DEPTH);
        chk("sim_no_ovf", {31'd0, overflow}, 0);
        chk("sim_full_after", {31'd0, full}, 1);
        wait_drain("simul");

        // Async reset during column 1 of vector 3
        bus.out_ready = 1'b0;
        for (int v = 0; v < DEPTH + 1; v++) cap_pattern(400 + v * 10, v < DEPTH);
        chk("mid_ovf_set", {31'd0, overflow}, 1);
        bus.out_ready = 1'b1;
        repeat (2 * COL + 1) tick();
        chk("mid_at_col1", {30'd0, bus.out_col}, 1);
        pulse_reset();
        capture('{-300, 301, -302, 303}, 1'b1);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 1);
        chk("post_rst_col", {30'd0, bus.out_col}, 0);
        wait_drain("post_reset");

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/psum_drain.md
# psum_drain

Output collector placed directly downstream of the MAC row. Captures the row's `col`-wide partial-sum vector on a valid pulse and buffers whole vectors in a FIFO of depth `depth`. Drains each vector one column at a time over a valid/ready stream, with optional ReLU, toward the output SRAM writer. Decouples the row's burst output from a back-pressured consumer.

## Interface
- `psum_bw`, default 20: width of one partial sum, two's-complement signed.
- `col`, default 4: psum words per vector; must be a power of two ≥ 2.
- `depth`, default 8: FIFO capacity in vectors; must be a power of two ≥ 2.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low (asserted when 0).
- `in_valid`  in  1: one-cycle capture strobe, driven by the row's load-out pulse.
- `in_psum`  in  `psum_bw` × `col` (unpacked array `[col-1:0]`): vector to capture.
- `relu_en`  in  1: when 1, negative words are emitted as 0.
- `out_ready`  in  1: consumer accepts `out_psum` this cycle.
- `out_valid`  out  1: `out_psum` holds a valid word.
- `out_psum`  out  `psum_bw`: current word.
- `out_col`  out  `$clog2(col)`: column index of `out_psum`.
- `out_last`  out  1: high with the word where `out_col == col-1`.
- `count`  out  `$clog2(depth)+1`: number of vectors stored.
- `full`  out  1: `count == depth`.
- `overflow`  out  1: sticky; set when a capture is dropped.

## Operation
- Storage: `depth` × `col` × `psum_bw` registers, write pointer `wr_ptr`, read pointer `rd_ptr`, column counter `col_idx`, and vector count `count`. Pointers wrap modulo `depth`.
- Write: at an edge with `in_valid=1`, if `count < depth` or a pop occurs in the same cycle, store `in_psum` at `wr_ptr` and increment `wr_ptr`. Otherwise drop the vector and set `overflow=1`. `overflow` clears only on reset.
- Output (combinational from registers): `out_valid = (count != 0)`.
  - `raw = mem[rd_ptr][col_idx]`.
  - `out_psum = (relu_en && raw[psum_bw-1]) ? 0 : raw`.
  - `out_col = col_idx`, `out_last = out_valid && (col_idx == col-1)`.
- Transfer: a word transfers when `out_valid && out_ready`. Each transfer increments `col_idx`.
  - On a transfer with `out_last=1` (pop): `col_idx` wraps to 0, `rd_ptr` increments, and the vector is freed.
- `count` update:
  - +1 on write without pop.
  - −1 on pop without write.
  - Unchanged when both or neither occur.
- Drain states, implied by `count` and `col_idx`:
  - EMPTY (`count==0`).
  - STREAM (`count>0`), with sub-position `col_idx`.
  - EMPTY→STREAM on a write.
  - STREAM→EMPTY on a pop with `count==1` and no write.
- `out_psum` and `out_col` must stay stable while `out_valid=1 && out_ready=0`.
- `relu_en` is sampled per word at output time and is not stored with the vector.
- Reset (asynchronous, mid-operation included): `wr_ptr`, `rd_ptr`, `col_idx`, and `count` go to 0; `overflow=0`. All stored vectors are discarded. Data RAM contents need no reset.

## Timing
- Reset values: `out_valid=0`, `out_col=0`, `out_last=0`, `count=0`, `full=0`, `overflow=0`. `out_psum` is don't-care while `out_valid=0`.
- Capture latency: `in_valid` sampled at edge k into an empty FIFO → `out_valid=1` in the cycle after edge k. Column 0 is presented first.
- Throughput: one word per cycle with `out_ready` held high. A vector drains in `col` cycles. Back-to-back vectors drain with no bubble.
- Full with a simultaneous write and pop: the write is accepted, `count` stays `depth`, and `overflow` is not set.
- Full with a write but no pop: the vector is dropped, `overflow` rises after that edge, and `count` is unchanged.
- Write while empty and `out_ready=1` in the same cycle: the new vector is not visible until the next cycle; no same-cycle bypass.
- Reset deassertion is synchronised externally. The first capture is legal on the first edge after `reset` reads 1.

## Test plan
- Single vector: capture {−5, 7, 0, 100} with `relu_en=0` and `out_ready=1` → `out_valid` the cycle after capture; words −5, 7, 0, 100 on consecutive cycles with `out_col` 0..3; `out_last` only on 100; `count` 1→0.
- ReLU: same vector with `relu_en=1` → 0, 7, 0, 100. Toggle `relu_en` mid-vector and confirm it applies per word.
- Back-pressure: drop `out_ready` for 3 cycles on column 2 → `out_psum` and `out_col` held stable; stream resumes at column 2 with no loss or duplication.
- Fill/overflow: `out_ready=0`, 9 captures with `depth=8` → `full=1` after the 8th; 9th dropped, `overflow=1`. Draining yields vectors 1–8 in order, 32 words, then `out_valid=0`.
- Full with simultaneous write and pop: FIFO full, capture on the edge where `out_last` transfers → `count` stays 8, `overflow` stays 0, new vector emitted last.
- Async reset mid-stream: assert `reset=0` between edges during column 1 of vector 3 → immediately `out_valid=0`, `count=0`, `overflow=0`. After release, a new capture streams from column 0.
